// File: rtl/noc_link_tx.sv
// Credit-based flit transmitter: buffers local flits in a small FIFO and launches
// them toward a router input port only while a downstream credit is held.
module noc_link_tx #(
  parameter int FLIT_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FLIT_W-1:0]                flit_i,
  input  logic                             flit_valid_i,
  output logic                             flit_ready_o,
  output logic [FLIT_W-1:0]                data_o,
  output logic                             valid_o,
  input  logic                             incr_i,
  output logic [$clog2(CREDITS+1)-1:0]     credits_o,
  output logic                             err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = $clog2(CREDITS + 1);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CRD_W-1:0] CRD_ONE  = CRD_W'(1);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(CREDITS);

  logic [FLIT_W-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [CRD_W-1:0]  credits_reg, credits_next;
  logic              err_reg, err_next;
  logic [FLIT_W-1:0] data_reg, data_next;
  logic              valid_reg;
  logic              push;
  logic              pop;
  logic              overflow;

  // Both handshakes look only at registered state, so a same-cycle pop never
  // frees a slot and a same-cycle credit return never enables a launch.
  assign flit_ready_o = (count_reg != CNT_FULL);
  assign push         = flit_valid_i & flit_ready_o;
  assign pop          = (count_reg != '0) & (credits_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= flit_i;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    data_next   = data_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
      data_next   = mem[rd_ptr_reg];
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // A return that would push the count past the downstream depth is a protocol
  // violation; the count saturates and the error is latched.
  always_comb begin
    credits_next = credits_reg;
    overflow     = 1'b0;
    if (pop && !incr_i) begin
      credits_next = credits_reg - CRD_ONE;
    end else if (!pop && incr_i) begin
      if (credits_reg == CRD_MAX) begin
        overflow = 1'b1;
      end else begin
        credits_next = credits_reg + CRD_ONE;
      end
    end
    err_next = err_reg | overflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      credits_reg <= CRD_MAX;
      err_reg     <= 1'b0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      credits_reg <= credits_next;
      err_reg     <= err_next;
      data_reg    <= data_next;
      valid_reg   <= pop;
    end
  end

  assign data_o    = data_reg;
  assign valid_o   = valid_reg;
  assign credits_o = credits_reg;
  assign err_o     = err_reg;

endmodule

// File: tb/tb_noc_link_tx.sv
// Bench for noc_link_tx: per-cycle vector table plus a push-order scoreboard on data_o.
module tb_noc_link_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] flit;
  logic        flit_valid;
  logic        flit_ready;
  logic [15:0] data;
  logic        valid;
  logic        incr;
  logic [2:0]  credits;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q [$];

  typedef struct {
    logic        fv;
    logic [15:0] fl;
    logic        inc;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  ec;
    logic        er;
    logic        ee;
  } vec_t;

  vec_t tbl [$];

  noc_link_tx #(.FLIT_W(16), .FIFO_DEPTH(4), .CREDITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_i       (flit),
    .flit_valid_i (flit_valid),
    .flit_ready_o (flit_ready),
    .data_o       (data),
    .valid_o      (valid),
    .incr_i       (incr),
    .credits_o    (credits),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Record accepted flits as they are driven, then advance one edge.
  task automatic step();
    if (flit_valid && flit_ready) exp_q.push_back(flit);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: data_o=%h with no flit pending", data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          n_err++;
          $display("FAIL sb_order: data_o=%h expected %h", data, e);
        end else begin
          $display("sb: flit %h delivered in order", data);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; flit = '0; flit_valid = 1'b0; incr = 1'b0;

    // Asynchronous reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_credits", 32'(credits), 32'd4);
    chk("rst_ready", 32'(flit_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Basic send: two clocks from push to data_o.
    flit = 16'hA5A5; flit_valid = 1'b1;
    step();
    flit_valid = 1'b0;
    chk("basic_valid_e1", 32'(valid), 32'd0);
    chk("basic_cred_e1", 32'(credits), 32'd4);
    step();
    chk("basic_valid_e2", 32'(valid), 32'd1);
    chk("basic_data_e2", 32'(data), 32'hA5A5);
    chk("basic_cred_e2", 32'(credits), 32'd3);
    step();
    chk("basic_valid_e3", 32'(valid), 32'd0);
    $display("basic send: data=%h credits=%0d", data, credits);
    incr = 1'b1;
    step();
    incr = 1'b0;
    chk("basic_cred_back", 32'(credits), 32'd4);

    //                fv    flit      inc   ev    data      cr    rdy   err
    tbl.push_back('{1'b1, 16'h0001, 1'b0, 1'b0, 16'hA5A5, 3'd4, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h0002, 1'b0, 1'b1, 16'h0001, 3'd3, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h0003, 1'b0, 1'b1, 16'h0002, 3'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h0004, 1'b0, 1'b1, 16'h0003, 3'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h0005, 1'b0, 1'b1, 16'h0004, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h0006, 1'b0, 1'b0, 16'h0004, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0004, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 3'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0005, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 3'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0006, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h0011, 1'b0, 1'b0, 16'h0006, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h0022, 1'b0, 1'b0, 16'h0006, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h0033, 1'b0, 1'b0, 16'h0006, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h0044, 1'b0, 1'b0, 16'h0006, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0006, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0006, 3'd1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 16'hBEEF, 1'b0, 1'b1, 16'h0011, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0011, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0011, 3'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0022, 3'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0033, 3'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0044, 3'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0044, 3'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h0A0A, 1'b0, 1'b0, 16'h0044, 3'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h0B0B, 1'b1, 1'b1, 16'h0A0A, 3'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 16'h0C0C, 1'b1, 1'b1, 16'h0B0B, 3'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0C0C, 3'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0C0C, 3'd2, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0C0C, 3'd3, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0C0C, 3'd4, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0C0C, 3'd4, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0C0C, 3'd4, 1'b1, 1'b1});

    for (int i = 0; i < tbl.size(); i++) begin
      flit_valid = tbl[i].fv;
      flit       = tbl[i].fl;
      incr       = tbl[i].inc;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_data", i), 32'(data), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_credits", i), 32'(credits), 32'(tbl[i].ec));
      chk($sformatf("vec%0d_ready", i), 32'(flit_ready), 32'(tbl[i].er));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].ee));
      $display("vec%0d: fv=%b flit=%h incr=%b -> valid=%b data=%h credits=%0d ready=%b err=%b",
               i, tbl[i].fv, tbl[i].fl, tbl[i].inc, valid, data, credits, flit_ready, err);
    end
    flit_valid = 1'b0; incr = 1'b0;

    // Mid-operation reset discards buffered flits and clears the sticky error.
    flit = 16'h7777; flit_valid = 1'b1;
    step();
    flit = 16'h8888;
    step();
    flit_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_data", 32'(data), 32'd0);
    chk("midrst_credits", 32'(credits), 32'd4);
    chk("midrst_ready", 32'(flit_ready), 32'd1);
    chk("midrst_err", 32'(err), 32'd0);
    $display("mid-cycle reset: valid=%b credits=%0d err=%b", valid, credits, err);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_idle", 32'(valid), 32'd0);

    flit = 16'h1234; flit_valid = 1'b1;
    step();
    flit_valid = 1'b0;
    step();
    chk("postrst_valid", 32'(valid), 32'd1);
    chk("postrst_data", 32'(data), 32'h1234);
    chk("postrst_credits", 32'(credits), 32'd3);
    @(negedge clk); #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
